imm_encoder: RTL and testbench

//  Inverse of the core's immediate extender: packs a 32-bit immediate plus register/opcode fields into
//  an I/S/B/U/J instruction word. Used by the boot/program loader to write instruction memory.
//  2-stage valid/ready pipeline; range-checks each immediate against its format.

---
 rtl/imm_encoder.sv | 144 ++++++++++++++
 tb/tb_imm_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: inverse of the core's immediate extender for the program loader. Packs an immediate
// plus register/opcode fields into an I/S/B/U/J word behind a 2-stage valid/ready pipeline.
module imm_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        imm_src,
  input  logic [31:0]       imm,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ins,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);

  // True when the masked bits are all copies of one value (fits the signed field).
  function automatic logic uniform(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == mask) || ((v & mask) == 32'h0000_0000);
  endfunction

  function automatic logic range_err(input logic [2:0] src, input logic [31:0] v);
    logic e;
    case (src)
      IMM_I, IMM_S: e = !uniform(v, 32'hFFFF_F800);
      IMM_B:        e = !uniform(v, 32'hFFFF_F000) || v[0];
      IMM_J:        e = !uniform(v, 32'hFFF0_0000) || v[0];
      IMM_U:        e = |v[11:0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  // Unknown formats fall through to the I layout.
  function automatic logic [31:0] encode(input logic [2:0] src, input logic [31:0] v,
                                         input logic [6:0] op, input logic [4:0] rd_f,
                                         input logic [2:0] f3, input logic [4:0] r1,
                                         input logic [4:0] r2);
    logic [31:0] w;
    case (src)
      IMM_S:   w = {v[11:5], r2, r1, f3, v[4:0], op};
      IMM_B:   w = {v[12], v[10:5], r2, r1, f3, v[4:1], v[11], op};
      IMM_U:   w = {v[31:12], rd_f, op};
      IMM_J:   w = {v[20], v[10:1], v[11], v[19:12], rd_f, op};
      default: w = {v[11:0], r1, f3, rd_f, op};
    endcase
    return w;
  endfunction

  logic              s1_valid_q, s2_valid_q;
  logic [2:0]        s1_src_q, s1_f3_q;
  logic [31:0]       s1_imm_q;
  logic [6:0]        s1_op_q;
  logic [4:0]        s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic              s1_err_q, s1_err_d;
  logic [31:0]       ins_q, ins_d;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        err_cnt_q;
  logic              s1_adv, s2_adv, out_hs;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_hs   = s2_valid_q && out_ready;
  assign in_ready = s1_adv;
  assign s1_err_d = range_err(imm_src, imm);
  assign ins_d    = encode(s1_src_q, s1_imm_q, s1_op_q, s1_rd_q, s1_f3_q, s1_rs1_q, s1_rs2_q);

  assign out_valid = s2_valid_q;
  assign out_ins   = ins_q;
  assign out_addr  = addr_q;
  assign out_err   = err_q;
  assign err_cnt   = err_cnt_q;

  // Clear outranks a same-cycle handshake: the beat is discarded and counters are not advanced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_src_q   <= 3'd0;
      s1_imm_q   <= 32'h0000_0000;
      s1_op_q    <= 7'h00;
      s1_rd_q    <= 5'd0;
      s1_f3_q    <= 3'd0;
      s1_rs1_q   <= 5'd0;
      s1_rs2_q   <= 5'd0;
      s1_err_q   <= 1'b0;
      ins_q      <= 32'h0000_0000;
      err_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      err_cnt_q  <= 8'h00;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      addr_q     <= BASE_ADDR;
      err_cnt_q  <= 8'h00;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_src_q <= imm_src;
          s1_imm_q <= imm;
          s1_op_q  <= opcode;
          s1_rd_q  <= rd;
          s1_f3_q  <= funct3;
          s1_rs1_q <= rs1;
          s1_rs2_q <= rs2;
          s1_err_q <= s1_err_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          ins_q <= ins_d;
          err_q <= s1_err_q;
        end
      end
      if (out_hs) begin
        addr_q <= addr_q + ADDR_STEP;
        if (err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_q <= err_cnt_q + 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed encodings, backpressure, clear and reset cases, then randomized
// beats scored against a queue model built from the format rules and a round-trip decoder.
module tb_imm_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk, rst, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  imm_src, funct3;
  logic [31:0] imm, out_ins, out_addr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [7:0]  err_cnt;

  imm_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .imm(imm), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
    .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        err;
    logic [31:0] imm;
    logic [2:0]  src;
    int          acc;
    logic        has_gold;
    logic [31:0] gold;
  } beat_t;

  beat_t       q[$];
  int          n_cmp = 0, n_mis = 0, cyc = 0, exp_ec = 0;
  logic [31:0] exp_addr = BASE;
  logic        last_in_hs = 1'b0, cur_has_gold = 1'b0;
  logic [31:0] cur_gold = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed ranges per format, written as plain integer bounds.
  function automatic logic ref_legal(input logic [2:0] src, input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    case (src)
      3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
      3'd2:       return (s >= -4096) && (s <= 4095) && ((v & 32'h1) == 32'h0);
      3'd3:       return (v % 32'd4096) == 32'h0;
      3'd4:       return (s >= -1048576) && (s <= 1048575) && ((v & 32'h1) == 32'h0);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] src, input logic [31:0] v,
                                           input logic [6:0] op, input logic [4:0] d,
                                           input logic [2:0] f, input logic [4:0] r1,
                                           input logic [4:0] r2);
    logic [31:0] o, dd, ff, a, b;
    o = 32'(op); dd = 32'(d) << 7; ff = 32'(f) << 12; a = 32'(r1) << 15; b = 32'(r2) << 20;
    case (src)
      3'd1: return (((v >> 5) & 32'h7F) << 25) | b | a | ff | ((v & 32'h1F) << 7) | o;
      3'd2: return (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) | b | a | ff
                   | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7) | o;
      3'd3: return (v & 32'hFFFF_F000) | dd | o;
      3'd4: return (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                   | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12) | dd | o;
      default: return ((v & 32'hFFF) << 20) | a | ff | dd | o;
    endcase
  endfunction

  // The core's immediate extender: recovers the immediate from an encoded word.
  function automatic logic [31:0] ref_ext(input logic [2:0] src, input logic [31:0] w);
    logic [31:0] v;
    case (src)
      3'd1: begin
        v = ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
        if (w[31]) v = v - 32'd4096;
      end
      3'd2: begin
        v = ((w >> 31) << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5)
            | (((w >> 8) & 32'hF) << 1);
        if (w[31]) v = v - 32'd8192;
      end
      3'd3: v = w & 32'hFFFF_F000;
      3'd4: begin
        v = ((w >> 31) << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 32'h1) << 11)
            | (((w >> 21) & 32'h3FF) << 1);
        if (w[31]) v = v - 32'd2097152;
      end
      default: begin
        v = w >> 20;
        if (w[31]) v = v - 32'd4096;
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] legal_imm(input logic [2:0] src);
    int s;
    case (src)
      3'd2:    s = (int'($urandom_range(0, 8191)) - 4096) & ~1;
      3'd3:    return $urandom & 32'hFFFF_F000;
      3'd4:    s = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
      default: s = int'($urandom_range(0, 4095)) - 2048;
    endcase
    return 32'(s);
  endfunction

  // One clock: inputs were driven at the falling edge; check model vs DUT, then advance.
  task automatic cycle_step();
    beat_t b;
    logic  exp_ov, exp_ir;
    #1;
    exp_ov = (q.size() > 0) && (q[0].acc <= cyc - 2);
    exp_ir = !((q.size() >= 2) && !out_ready);
    check("out_valid", out_valid, exp_ov);
    check("in_ready", in_ready, exp_ir);
    check("err_cnt", err_cnt, exp_ec);
    last_in_hs = 1'b0;
    if (clear) begin
      q.delete();
      exp_addr = BASE;
      exp_ec   = 0;
    end else begin
      if (exp_ov && out_ready) begin
        b = q.pop_front();
        check("out_ins", out_ins, b.ins);
        check("out_err", out_err, b.err);
        check("out_addr", out_addr, exp_addr);
        if (b.has_gold) check("gold_ins", out_ins, b.gold);
        if (!b.err) check("round_trip", ref_ext(b.src, out_ins), b.imm);
        exp_addr = exp_addr + 32'd4;
        if (b.err && exp_ec < 255) exp_ec++;
      end
      if (in_valid && exp_ir) begin
        b.src = imm_src; b.imm = imm; b.acc = cyc;
        b.err = !ref_legal(imm_src, imm);
        b.ins = ref_word(imm_src, imm, opcode, rd, funct3, rs1, rs2);
        b.has_gold = cur_has_gold; b.gold = cur_gold;
        q.push_back(b);
        last_in_hs = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] s, input logic [31:0] v, input logic [6:0] op,
                      input logic [4:0] d, input logic [2:0] f, input logic [4:0] r1,
                      input logic [4:0] r2, input logic hg, input logic [31:0] g);
    int k;
    imm_src = s; imm = v; opcode = op; rd = d; funct3 = f; rs1 = r1; rs2 = r2;
    cur_has_gold = hg; cur_gold = g; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    do begin cycle_step(); k++; end while (!last_in_hs && k < 10);
    in_valid = 1'b0; cur_has_gold = 1'b0;
    k = 0;
    while (q.size() > 0 && k < 10) begin cycle_step(); k++; end
    check("send_drain", q.size(), 0);
  endtask

  initial begin
    int sent, k, nb;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = 3'd0; imm = 32'h0; opcode = 7'h0; rd = 5'd0; funct3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ins", out_ins, 0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_out_err", out_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    send(3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 1'b1, 32'hFFF1_0093);
    send(3'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 1'b1, 32'hFE20_8EE3);
    send(3'd2, 32'h0000_0003, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 1'b0, 32'h0);
    check("b_err_cnt", err_cnt, 1);
    send(3'd3, 32'h1234_5000, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 1'b1, 32'h1234_52B7);
    send(3'd3, 32'h1234_5001, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    check("u_err_cnt", err_cnt, 2);

    clear = 1'b1; cycle_step(); clear = 1'b0;
    check("clear_addr", out_addr, BASE);
    sent = 0; k = 0;
    while ((sent < 8 || q.size() > 0) && k < 80) begin
      out_ready = (k % 3 == 0);
      in_valid  = (sent < 8);
      imm_src = 3'd0; imm = 32'(sent * 8); rd = 5'(sent); opcode = 7'h13; rs1 = 5'd3;
      cycle_step();
      if (last_in_hs) sent++;
      k++;
    end
    check("bp_sent", sent, 8);
    check("bp_addr_end", out_addr, BASE + 32'd32);

    in_valid = 1'b1; out_ready = 1'b0; imm_src = 3'd1; imm = 32'h0000_0010;
    cycle_step();
    in_valid = 1'b0;
    cycle_step(); cycle_step();
    clear = 1'b1; out_ready = 1'b1;
    cycle_step();
    clear = 1'b0;
    cycle_step();
    check("clr_hs_valid", out_valid, 0);
    check("clr_hs_addr", out_addr, BASE);

    for (int s = 0; s < 8; s++) begin
      nb = (s < 5) ? 3000 : 200;
      sent = 0; k = 0; in_valid = 1'b0;
      while (sent < nb && k < nb * 4) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid || last_in_hs) begin
          in_valid = ($urandom_range(0, 3) != 0);
          imm_src = 3'(s); opcode = 7'($urandom); rd = 5'($urandom); funct3 = 3'($urandom);
          rs1 = 5'($urandom); rs2 = 5'($urandom);
          imm = ($urandom_range(0, 1) == 1) ? legal_imm(3'(s)) : $urandom;
        end
        cycle_step();
        if (last_in_hs) sent++;
        k++;
      end
      check("rand_sent", sent, nb);
    end
    in_valid = 1'b0; out_ready = 1'b1; k = 0;
    while (q.size() > 0 && k < 10) begin cycle_step(); k++; end
    check("rand_drain", q.size(), 0);
    check("err_cnt_sat", err_cnt, 255);

    in_valid = 1'b1; imm_src = 3'd0; imm = 32'h0000_0005;
    repeat (4) cycle_step();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_addr", out_addr, BASE);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_err_cnt", err_cnt, 0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    cyc++;
    q.delete(); exp_addr = BASE; exp_ec = 0;
    send(3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 1'b1, 32'hFFF1_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
